// File: rtl/dic_pkg.sv
// dic_pkg: shared constants for the clock control stage.
//   - 3-bit FSM state encoding and the state_t enum built on it
//   - ASCII codes for the command keys and the digit range
//   - fold_case(): maps 'A'-'Z' onto 'a'-'z', leaves everything else alone
package dic_pkg;

    localparam logic [2:0] S_STOP  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_LD_MT = 3'd2;
    localparam logic [2:0] S_LD_MO = 3'd3;
    localparam logic [2:0] S_LD_ST = 3'd4;
    localparam logic [2:0] S_LD_SO = 3'd5;

    typedef enum logic [2:0] {
        STOP  = S_STOP,
        RUN   = S_RUN,
        LD_MT = S_LD_MT,
        LD_MO = S_LD_MO,
        LD_ST = S_LD_ST,
        LD_SO = S_LD_SO
    } state_t;

    localparam logic [7:0] ASC_R = 8'h72;  // 'r'
    localparam logic [7:0] ASC_S = 8'h73;  // 's'
    localparam logic [7:0] ASC_L = 8'h6c;  // 'l'
    localparam logic [7:0] ASC_N = 8'h6e;  // 'n'
    localparam logic [7:0] ASC_0 = 8'h30;  // '0'
    localparam logic [7:0] ASC_9 = 8'h39;  // '9'

    function automatic logic [7:0] fold_case(input logic [7:0] c);
        if (c >= 8'h41 && c <= 8'h5a) return c | 8'h20;
        return c;
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// sec_tick_gen: free-running one-second timebase.
//   clk, rst  : clock, asynchronous active-low reset
//   strb      : one-cycle strobe at the start of every second
//   pulse     : high for the first half of every second
// The counter wraps 0..CLKS_PER_SEC-1 and never stops. strb is the registered
// wrap condition, so the first strobe lands CLKS_PER_SEC edges after reset
// release; pulse is registered from the next count so it lines up with strb
// (high for the cycle of strb and the following CLKS_PER_SEC/2-1 cycles).
module sec_tick_gen #(
    parameter int CLKS_PER_SEC = 100_000_000,
    parameter int CNT_W        = 27
) (
    input  logic clk,
    input  logic rst,
    output logic strb,
    output logic pulse
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_SEC - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_SEC / 2);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    assign cnt_nxt = (cnt == LAST) ? '0 : cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            strb  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            strb  <= (cnt == LAST);
            pulse <= (cnt_nxt < HALF);
        end
    end

endmodule

// File: rtl/dic_ctrl_fsm.sv
// dic_ctrl_fsm: control stage in front of the clock datapath.
//   clk, rst                 : clock, asynchronous active-low reset
//   key_vld, key_code[7:0]   : one-cycle ASCII keystroke
//   o_oneSecStrb/Pluse       : one-second strobe and 50% pulse
//   dicRun                   : datapath counts while high (RUN state)
//   dicSelectLEDdisp         : one-cycle pulse on 'n'
//   ldMtens..ldSones, ld_num : one-cycle digit load pulses and digit value
//   dic_loading              : high while in any LD_* state
// Keys are case-folded and decoded combinationally; state and every output
// are registered together, so all key effects appear one cycle after key_vld.
module dic_ctrl_fsm
    import dic_pkg::*;
#(
    parameter int CLKS_PER_SEC = 100_000_000,
    parameter int CNT_W        = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_vld,
    input  logic [7:0] key_code,
    output logic       o_oneSecStrb,
    output logic       o_oneSecPluse,
    output logic       dicRun,
    output logic       dicSelectLEDdisp,
    output logic       ldMtens,
    output logic       ldMones,
    output logic       ldStens,
    output logic       ldSones,
    output logic [3:0] ld_num,
    output logic       dic_loading
);

    sec_tick_gen #(
        .CLKS_PER_SEC(CLKS_PER_SEC),
        .CNT_W       (CNT_W)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .strb (o_oneSecStrb),
        .pulse(o_oneSecPluse)
    );

    logic [7:0] key;
    logic       is_dig;
    logic [3:0] dig;

    assign key    = fold_case(key_code);
    assign is_dig = (key >= ASC_0) && (key <= ASC_9);
    assign dig    = key[3:0];  // '0'..'9' are 0x30..0x39

    state_t     state, nxt;
    logic [3:0] ld_nxt;   // one-hot {Mtens, Mones, Stens, Sones}
    logic       sel_nxt;

    // 'r', 's' and 'l' behave the same from every state (RUN stays RUN on 'r',
    // STOP stays STOP on 's'), so only digits depend on the current state.
    always_comb begin
        nxt     = state;
        ld_nxt  = '0;
        sel_nxt = 1'b0;
        if (key_vld) begin
            if (key == ASC_N) begin
                sel_nxt = 1'b1;
            end else if (key == ASC_R) begin
                nxt = RUN;
            end else if (key == ASC_S) begin
                nxt = STOP;
            end else if (key == ASC_L) begin
                nxt = LD_MT;
            end else if (is_dig) begin
                case (state)
                    LD_MT: if (dig <= 4'd5) begin ld_nxt = 4'b1000; nxt = LD_MO; end
                    LD_MO: begin ld_nxt = 4'b0100; nxt = LD_ST; end
                    LD_ST: if (dig <= 4'd5) begin ld_nxt = 4'b0010; nxt = LD_SO; end
                    LD_SO: begin ld_nxt = 4'b0001; nxt = STOP; end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= STOP;
            dicRun           <= 1'b0;
            dicSelectLEDdisp <= 1'b0;
            ldMtens          <= 1'b0;
            ldMones          <= 1'b0;
            ldStens          <= 1'b0;
            ldSones          <= 1'b0;
            ld_num           <= '0;
            dic_loading      <= 1'b0;
        end else begin
            state            <= nxt;
            dicRun           <= (nxt == RUN);
            dicSelectLEDdisp <= sel_nxt;
            {ldMtens, ldMones, ldStens, ldSones} <= ld_nxt;
            ld_num           <= (|ld_nxt) ? dig : 4'd0;
            dic_loading      <= (nxt == LD_MT) || (nxt == LD_MO) ||
                                (nxt == LD_ST) || (nxt == LD_SO);
        end
    end

endmodule

// File: tb/tb_dic_ctrl_fsm.sv
// tb_dic_ctrl_fsm: directed bench for dic_ctrl_fsm with CLKS_PER_SEC=10.
// Each key step pushes its expected key-side outputs onto a scoreboard queue;
// the entry is popped and compared one edge later when the DUT responds.
module tb_dic_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_vld = 1'b0;
    logic [7:0] key_code = 8'h00;
    logic       o_oneSecStrb, o_oneSecPluse, dicRun, dicSelectLEDdisp;
    logic       ldMtens, ldMones, ldStens, ldSones, dic_loading;
    logic [3:0] ld_num;

    dic_ctrl_fsm #(.CLKS_PER_SEC(10), .CNT_W(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .key_vld         (key_vld),
        .key_code        (key_code),
        .o_oneSecStrb    (o_oneSecStrb),
        .o_oneSecPluse   (o_oneSecPluse),
        .dicRun          (dicRun),
        .dicSelectLEDdisp(dicSelectLEDdisp),
        .ldMtens         (ldMtens),
        .ldMones         (ldMones),
        .ldStens         (ldStens),
        .ldSones         (ldSones),
        .ld_num          (ld_num),
        .dic_loading     (dic_loading)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       run;
        logic       sel;
        logic [3:0] ld;
        logic [3:0] num;
        logic       loading;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t obs_now();
        exp_t o;
        o.run     = dicRun;
        o.sel     = dicSelectLEDdisp;
        o.ld      = {ldMtens, ldMones, ldStens, ldSones};
        o.num     = ld_num;
        o.loading = dic_loading;
        return o;
    endfunction

    task automatic check_bits(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sb_compare(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=empty scoreboard expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            check_bits(tag, 16'(obs_now()), 16'(e));
        end
    endtask

    task automatic push(input logic run, input logic sel, input logic [3:0] ld,
                        input logic [3:0] num, input logic loading);
        exp_t e;
        e.run = run; e.sel = sel; e.ld = ld; e.num = num; e.loading = loading;
        exp_q.push_back(e);
    endtask

    // Drive one key for one cycle; the next call drives immediately, so
    // consecutive calls are back-to-back key_vld cycles.
    task automatic key(input logic [7:0] c, input string tag, input logic run, input logic sel,
                       input logic [3:0] ld, input logic [3:0] num, input logic loading);
        push(run, sel, ld, num, loading);
        key_vld  = 1'b1;
        key_code = c;
        @(posedge clk); #1;
        key_vld  = 1'b0;
        key_code = 8'h00;
        sb_compare(tag);
    endtask

    task automatic idle(input string tag, input logic run, input logic loading);
        push(run, 1'b0, 4'b0000, 4'd0, loading);
        @(posedge clk); #1;
        sb_compare(tag);
    endtask

    function automatic logic [15:0] all_outs();
        return {3'b000, o_oneSecStrb, o_oneSecPluse, dicRun, dicSelectLEDdisp,
                ldMtens, ldMones, ldStens, ldSones, ld_num, dic_loading};
    endfunction

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_bits("reset_outputs", all_outs(), 16'h0000);

        // 1. Timebase: after k edges, strobe when k%10==0, pulse when k%10<5
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            @(posedge clk); #1;
            check_bits($sformatf("tick_k%0d", k), {13'd0, o_oneSecStrb, o_oneSecPluse, dicRun},
                       {13'd0, (k % 10) == 0, (k % 10) < 5, 1'b0});
        end

        // 2. Full load sequence, keys back-to-back
        key("l", "load_enter", 0, 0, 4'b0000, 4'd0, 1);
        key("1", "ld_mtens",   0, 0, 4'b1000, 4'd1, 1);
        key("2", "ld_mones",   0, 0, 4'b0100, 4'd2, 1);
        key("3", "ld_stens",   0, 0, 4'b0010, 4'd3, 1);
        key("4", "ld_sones",   0, 0, 4'b0001, 4'd4, 0);
        idle("load_done_stop", 0, 0);

        // 3. Out-of-range tens digit ignored, then valid one accepted
        key("L", "load_upper",   0, 0, 4'b0000, 4'd0, 1);
        key("7", "mt_range_ign", 0, 0, 4'b0000, 4'd0, 1);
        idle("mt_hold", 0, 1);
        key("5", "mt_5",         0, 0, 4'b1000, 4'd5, 1);
        key("9", "mo_9",         0, 0, 4'b0100, 4'd9, 1);
        key("6", "st_range_ign", 0, 0, 4'b0000, 4'd0, 1);
        key("s", "abort_stop",   0, 0, 4'b0000, 4'd0, 0);

        // 4. Run/stop and LED select
        key("R", "run_upper",  1, 0, 4'b0000, 4'd0, 0);
        idle("run_hold", 1, 0);
        key("x", "unknown_ign", 1, 0, 4'b0000, 4'd0, 0);
        key("N", "sel_in_run", 1, 1, 4'b0000, 4'd0, 0);
        key("s", "stop",       0, 0, 4'b0000, 4'd0, 0);
        key("n", "sel_in_stop", 0, 1, 4'b0000, 4'd0, 0);
        idle("sel_single", 0, 0);

        // 5. Abort a load into RUN; later digits ignored
        key("l", "load2_enter", 0, 0, 4'b0000, 4'd0, 1);
        key("2", "load2_mt",    0, 0, 4'b1000, 4'd2, 1);
        key("r", "abort_run",   1, 0, 4'b0000, 4'd0, 0);
        key("3", "digit_in_run", 1, 0, 4'b0000, 4'd0, 0);
        idle("run_after_abort", 1, 0);
        key("l", "load_from_run", 0, 0, 4'b0000, 4'd0, 1);
        key("l", "load_restart",  0, 0, 4'b0000, 4'd0, 1);
        key("s", "stop2",         0, 0, 4'b0000, 4'd0, 0);

        // 6. Async reset while ldMones pulse is on the outputs
        key("l", "load3_enter", 0, 0, 4'b0000, 4'd0, 1);
        key("1", "load3_mt",    0, 0, 4'b1000, 4'd1, 1);
        key("2", "load3_mo",    0, 0, 4'b0100, 4'd2, 1);
        #2 rst = 1'b0;
        #1 check_bits("async_reset_cut", all_outs(), 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        // Counter restarted; a key landing on the strobe edge also takes effect
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            key_vld  = 1'b0;
            key_code = 8'h00;
            check_bits($sformatf("restart_k%0d", k),
                       {13'd0, o_oneSecStrb, o_oneSecPluse, dicRun},
                       {13'd0, (k % 10) == 0, (k % 10) < 5, k >= 10});
            if (k == 9) begin
                key_vld  = 1'b1;
                key_code = "r";
            end
        end
        key("3", "digit_after_restart", 1, 0, 4'b0000, 4'd0, 0);

        check_bits("scoreboard_drained", 16'(exp_q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case the run ever stalls
    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
